// File: rtl/baser_pkg.sv
// Shared definitions for the BASE-R 64B/66B transmit encoder.
// Holds MII control characters, 66b block-type values, 7-bit control
// codes, sync headers, the transmit FSM state enum, the MII word-type
// enum and small helper functions used by the encoder and the top.
package baser_pkg;

    // MII control characters
    localparam logic [7:0] MII_IDLE  = 8'h07;
    localparam logic [7:0] MII_START = 8'hFB;
    localparam logic [7:0] MII_TERM  = 8'hFD;
    localparam logic [7:0] MII_ERROR = 8'hFE;
    localparam logic [7:0] MII_SEQ   = 8'h9C;

    // 66b block-type field values
    localparam logic [7:0] BT_CTRL  = 8'h1E;
    localparam logic [7:0] BT_START = 8'h78;
    localparam logic [7:0] BT_OSET  = 8'h4B;

    // 7-bit control codes carried in control blocks
    localparam logic [6:0] CODE_IDLE  = 7'h00;
    localparam logic [6:0] CODE_ERROR = 7'h1E;

    // Sync headers
    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    // Error block substituted on illegal transmit sequences
    localparam logic [65:0] EBLOCK_T = {{8{CODE_ERROR}}, BT_CTRL, SYNC_CTRL};

    typedef enum logic [2:0] {
        TX_INIT = 3'd0,
        TX_C    = 3'd1,
        TX_D    = 3'd2,
        TX_T    = 3'd3,
        TX_E    = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        WT_C = 3'd0,
        WT_S = 3'd1,
        WT_O = 3'd2,
        WT_T = 3'd3,
        WT_D = 3'd4,
        WT_E = 3'd5
    } word_type_t;

    // True when a control byte may appear in a C position (idle or error)
    function automatic logic is_ctrl_ok(input logic [7:0] b);
        return (b == MII_IDLE) || (b == MII_ERROR);
    endfunction

    // Map an idle/error MII byte to its 7-bit code
    function automatic logic [6:0] mii_to_code(input logic [7:0] b);
        logic [6:0] code;
        if (b == MII_ERROR) begin
            code = CODE_ERROR;
        end else begin
            code = CODE_IDLE;
        end
        return code;
    endfunction

    // Block type for a terminate block whose /T/ sits in lane k
    function automatic logic [7:0] term_type(input logic [2:0] k);
        logic [7:0] t;
        case (k)
            3'd0:    t = 8'h87;
            3'd1:    t = 8'h99;
            3'd2:    t = 8'hAA;
            3'd3:    t = 8'hB4;
            3'd4:    t = 8'hCC;
            3'd5:    t = 8'hD2;
            3'd6:    t = 8'hE1;
            3'd7:    t = 8'hFF;
            default: t = 8'hFF;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/baser_66b_block_encoder.sv
// Combinational classifier and 64B/66B block encoder for one MII word.
// Ports:
//   txd        - 64b MII data, lane 0 = bits [7:0]
//   txc        - 8b MII control, bit k flags lane k
//   block      - encoded 66b block (EBLOCK_T when the word is type E)
//   word_type  - classification C/S/O/T/D/E used by the transmit FSM
module baser_66b_block_encoder
    import baser_pkg::*;
#(
    parameter int         DATA_WIDTH  = 64,
    parameter int         HDR_WIDTH   = 2,
    parameter int         FRAME_WIDTH = DATA_WIDTH + HDR_WIDTH,
    parameter int         CTRL_WIDTH  = DATA_WIDTH / 8,
    parameter logic [3:0] OSET_CODE   = 4'hB
) (
    input  logic [DATA_WIDTH-1:0]  txd,
    input  logic [CTRL_WIDTH-1:0]  txc,
    output logic [FRAME_WIDTH-1:0] block,
    output word_type_t             word_type
);

    // Locate a legal terminate: txc has lanes >= k set, lane k is /T/ and
    // every later lane is idle or error. Returns {hit, lane}.
    function automatic logic [3:0] find_term(input logic [63:0] d, input logic [7:0] c);
        logic [3:0] r;
        logic       ok;
        r = 4'h0;
        for (int k = 0; k < 8; k++) begin
            ok = (c == (8'hFF << k)) && (d[8*k +: 8] == MII_TERM);
            for (int j = k + 1; j < 8; j++) begin
                ok = ok & is_ctrl_ok(d[8*j +: 8]);
            end
            if (ok) begin
                r = {1'b1, 3'(k)};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Terminate payload: k data bytes, (7-k) zero bits, then (7-k) codes
    function automatic logic [55:0] term_payload(input logic [63:0] d, input logic [2:0] k);
        logic [55:0] p;
        int          kk;
        int          pos;
        p  = 56'h0;
        kk = int'(k);
        for (int i = 0; i < 8; i++) begin
            if (i < kk) begin
                p = p | (56'(d[8*i +: 8]) << (8 * i));
            end else if (i > kk) begin
                pos = 8 * kk + (7 - kk) + 7 * (i - kk - 1);
                p   = p | (56'(mii_to_code(d[8*i +: 8])) << pos);
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

    // All-control payload: eight 7-bit codes, lane 0 lowest
    function automatic logic [55:0] ctrl_payload(input logic [63:0] d);
        logic [55:0] p;
        p = 56'h0;
        for (int i = 0; i < 8; i++) begin
            p = p | (56'(mii_to_code(d[8*i +: 8])) << (7 * i));
        end
        return p;
    endfunction

    logic [3:0] term_s;
    logic [7:0] lane_ok_s;

    assign term_s = find_term(txd, txc);

    // Per-lane idle/error flags for the all-control check
    always_comb begin
        lane_ok_s = 8'h00;
        for (int i = 0; i < 8; i++) begin
            lane_ok_s[i] = is_ctrl_ok(txd[8*i +: 8]);
        end
    end

    // Classify the word and build the matching block
    always_comb begin
        block     = EBLOCK_T;
        word_type = WT_E;
        if (txc == 8'h00) begin
            word_type = WT_D;
            block     = {txd, SYNC_DATA};
        end else if ((txc == 8'hFF) && (&lane_ok_s)) begin
            word_type = WT_C;
            block     = {ctrl_payload(txd), BT_CTRL, SYNC_CTRL};
        end else if ((txc == 8'h01) && (txd[7:0] == MII_START)) begin
            word_type = WT_S;
            block     = {txd[63:8], BT_START, SYNC_CTRL};
        end else if ((txc == 8'hF1) && (txd[7:0] == MII_SEQ) &&
                     (txd[63:32] == {4{MII_IDLE}})) begin
            word_type = WT_O;
            block     = {28'h0, OSET_CODE, txd[31:8], BT_OSET, SYNC_CTRL};
        end else if (term_s[3]) begin
            word_type = WT_T;
            block     = {term_payload(txd, term_s[2:0]), term_type(term_s[2:0]), SYNC_CTRL};
        end else begin
            word_type = WT_E;
            block     = EBLOCK_T;
        end
    end

endmodule

// File: rtl/mii_baser_66b_encoder.sv
// 1.6TMII to 64B/66B transmit encoder with sequencing check and 4-block gather.
// Ports:
//   clk, i_rst_n        - clock, asynchronous active-low reset
//   i_valid             - MII word on i_txd/i_txc accepted this cycle
//   i_txd, i_txc        - MII data (lane 0 = [7:0]) and control
//   o_tx_coded_0..3     - four gathered 66b blocks, lane 0 oldest
//   o_valid             - one-cycle strobe when o_tx_coded_* update
//   o_block_count, o_data_count, o_ctrl_count, o_err_count - statistics
module mii_baser_66b_encoder
    import baser_pkg::*;
#(
    parameter int         DATA_WIDTH  = 64,
    parameter int         HDR_WIDTH   = 2,
    parameter int         FRAME_WIDTH = DATA_WIDTH + HDR_WIDTH,
    parameter int         CTRL_WIDTH  = DATA_WIDTH / 8,
    parameter logic [3:0] OSET_CODE   = 4'hB
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    input  logic [DATA_WIDTH-1:0]  i_txd,
    input  logic [CTRL_WIDTH-1:0]  i_txc,
    output logic [FRAME_WIDTH-1:0] o_tx_coded_0,
    output logic [FRAME_WIDTH-1:0] o_tx_coded_1,
    output logic [FRAME_WIDTH-1:0] o_tx_coded_2,
    output logic [FRAME_WIDTH-1:0] o_tx_coded_3,
    output logic                   o_valid,
    output logic [31:0]            o_block_count,
    output logic [31:0]            o_data_count,
    output logic [31:0]            o_ctrl_count,
    output logic [31:0]            o_err_count
);

    logic [FRAME_WIDTH-1:0] enc_blk_s;
    word_type_t             wtype_s;
    tx_state_t              state_r;
    tx_state_t              state_nxt_s;
    logic [FRAME_WIDTH-1:0] tx_blk_s;
    logic                   to_err_s;

    logic [FRAME_WIDTH-1:0] s1_blk_r;
    logic [1:0]             s1_slot_r;
    logic                   s1_vld_r;
    logic [1:0]             slot_r;

    logic [FRAME_WIDTH-1:0] buf0_r, buf1_r, buf2_r;
    logic [FRAME_WIDTH-1:0] out0_r, out1_r, out2_r, out3_r;
    logic                   out_vld_r;
    logic [31:0]            blk_cnt_r, data_cnt_r, ctrl_cnt_r, err_cnt_r;

    baser_66b_block_encoder #(
        .DATA_WIDTH  (DATA_WIDTH),
        .HDR_WIDTH   (HDR_WIDTH),
        .FRAME_WIDTH (FRAME_WIDTH),
        .CTRL_WIDTH  (CTRL_WIDTH),
        .OSET_CODE   (OSET_CODE)
    ) u_enc (
        .txd       (i_txd),
        .txc       (i_txc),
        .block     (enc_blk_s),
        .word_type (wtype_s)
    );

    // Transmit sequencing: next state from current state and word type
    always_comb begin
        state_nxt_s = TX_E;
        case (state_r)
            TX_INIT, TX_C, TX_T: begin
                if ((wtype_s == WT_C) || (wtype_s == WT_O)) begin
                    state_nxt_s = TX_C;
                end else if (wtype_s == WT_S) begin
                    state_nxt_s = TX_D;
                end else begin
                    state_nxt_s = TX_E;
                end
            end
            TX_D: begin
                if (wtype_s == WT_D) begin
                    state_nxt_s = TX_D;
                end else if (wtype_s == WT_T) begin
                    state_nxt_s = TX_T;
                end else begin
                    state_nxt_s = TX_E;
                end
            end
            TX_E: begin
                if ((wtype_s == WT_C) || (wtype_s == WT_O)) begin
                    state_nxt_s = TX_C;
                end else if (wtype_s == WT_D) begin
                    state_nxt_s = TX_D;
                end else if (wtype_s == WT_T) begin
                    state_nxt_s = TX_T;
                end else begin
                    state_nxt_s = TX_E;
                end
            end
            default: state_nxt_s = TX_E;
        endcase
    end

    // Every entry into E sends the error block instead of the encoded one
    assign to_err_s = (state_nxt_s == TX_E);
    assign tx_blk_s = to_err_s ? EBLOCK_T : enc_blk_s;

    // Stage 1: FSM state, slot counter and registered block
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= TX_INIT;
            slot_r    <= 2'd0;
            s1_slot_r <= 2'd0;
            s1_blk_r  <= '0;
            s1_vld_r  <= 1'b0;
        end else if (i_valid) begin
            state_r   <= state_nxt_s;
            slot_r    <= slot_r + 2'd1;
            s1_slot_r <= slot_r;
            s1_blk_r  <= tx_blk_s;
            s1_vld_r  <= 1'b1;
        end else begin
            s1_vld_r  <= 1'b0;
        end
    end

    // Statistics counters, advanced once per accepted word
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blk_cnt_r  <= 32'd0;
            data_cnt_r <= 32'd0;
            ctrl_cnt_r <= 32'd0;
            err_cnt_r  <= 32'd0;
        end else if (i_valid) begin
            blk_cnt_r <= blk_cnt_r + 32'd1;
            if (tx_blk_s[1:0] == SYNC_DATA) begin
                data_cnt_r <= data_cnt_r + 32'd1;
            end else begin
                ctrl_cnt_r <= ctrl_cnt_r + 32'd1;
            end
            if (to_err_s) begin
                err_cnt_r <= err_cnt_r + 32'd1;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end else begin
            blk_cnt_r <= blk_cnt_r;
        end
    end

    // Stage 2: buffer slots 0-2, then publish all four on slot 3
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            buf0_r    <= '0;
            buf1_r    <= '0;
            buf2_r    <= '0;
            out0_r    <= '0;
            out1_r    <= '0;
            out2_r    <= '0;
            out3_r    <= '0;
            out_vld_r <= 1'b0;
        end else begin
            out_vld_r <= 1'b0;
            if (s1_vld_r) begin
                case (s1_slot_r)
                    2'd0: buf0_r <= s1_blk_r;
                    2'd1: buf1_r <= s1_blk_r;
                    2'd2: buf2_r <= s1_blk_r;
                    2'd3: begin
                        out0_r    <= buf0_r;
                        out1_r    <= buf1_r;
                        out2_r    <= buf2_r;
                        out3_r    <= s1_blk_r;
                        out_vld_r <= 1'b1;
                    end
                    default: out_vld_r <= 1'b0;
                endcase
            end else begin
                out_vld_r <= 1'b0;
            end
        end
    end

    assign o_tx_coded_0  = out0_r;
    assign o_tx_coded_1  = out1_r;
    assign o_tx_coded_2  = out2_r;
    assign o_tx_coded_3  = out3_r;
    assign o_valid       = out_vld_r;
    assign o_block_count = blk_cnt_r;
    assign o_data_count  = data_cnt_r;
    assign o_ctrl_count  = ctrl_cnt_r;
    assign o_err_count   = err_cnt_r;

endmodule

// File: tb/tb_mii_baser_66b_encoder.sv
// Directed self-checking bench for mii_baser_66b_encoder.
module tb_mii_baser_66b_encoder;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic [63:0] i_txd;
    logic [7:0]  i_txc;
    logic [65:0] o_tx_coded_0, o_tx_coded_1, o_tx_coded_2, o_tx_coded_3;
    logic        o_valid;
    logic [31:0] o_block_count, o_data_count, o_ctrl_count, o_err_count;

    mii_baser_66b_encoder dut (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .i_txd         (i_txd),
        .i_txc         (i_txc),
        .o_tx_coded_0  (o_tx_coded_0),
        .o_tx_coded_1  (o_tx_coded_1),
        .o_tx_coded_2  (o_tx_coded_2),
        .o_tx_coded_3  (o_tx_coded_3),
        .o_valid       (o_valid),
        .o_block_count (o_block_count),
        .o_data_count  (o_data_count),
        .o_ctrl_count  (o_ctrl_count),
        .o_err_count   (o_err_count)
    );

    always #5 clk = ~clk;

    localparam logic [7:0]  IDLE_C   = 8'hFF;
    localparam logic [63:0] IDLE_D   = 64'h0707070707070707;
    localparam logic [65:0] IDLE_BLK = {56'h0, 8'h1E, 2'b01};
    localparam logic [65:0] EBLK     = {{8{7'h1E}}, 8'h1E, 2'b01};
    localparam logic [65:0] S_BLK    = {56'hAAAAAAAAAAAAAA, 8'h78, 2'b01};
    localparam logic [65:0] DAA_BLK  = {64'hAAAAAAAAAAAAAAAA, 2'b10};

    int checks = 0;
    int errors = 0;

    logic [65:0] cap [0:31][0:3];
    int          ngrp = 0;

    // Record every output group seen with o_valid
    always @(negedge clk) begin
        if (o_valid && ngrp < 32) begin
            cap[ngrp][0] = o_tx_coded_0;
            cap[ngrp][1] = o_tx_coded_1;
            cap[ngrp][2] = o_tx_coded_2;
            cap[ngrp][3] = o_tx_coded_3;
            ngrp++;
        end
    end

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic v, input logic [7:0] c, input logic [63:0] d);
        i_valid = v;
        i_txc   = c;
        i_txd   = d;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic flush();
        send(1'b0, IDLE_C, IDLE_D);
        send(1'b0, IDLE_C, IDLE_D);
    endtask

    task automatic check_lane(input string tag, input int g, input int l, input logic [65:0] exp);
        if (g < ngrp) begin
            check($sformatf("%s_g%0d_l%0d", tag, g, l), cap[g][l], exp);
        end else begin
            check($sformatf("%s_missing_g%0d", tag, g), 66'(ngrp), 66'(g + 1));
        end
    endtask

    logic [7:0]  tt [0:7];
    logic [63:0] d;
    logic [7:0]  c;
    logic [55:0] p;
    int          base;

    initial begin
        tt = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_txc   = IDLE_C;
        i_txd   = IDLE_D;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 66'(o_valid), 66'd0);
        check("rst_lane0", o_tx_coded_0, 66'd0);
        check("rst_blocks", 66'(o_block_count), 66'd0);
        i_rst_n = 1'b1;

        // Eight idle words -> two groups of idle blocks
        for (int i = 0; i < 8; i++) send(1'b1, IDLE_C, IDLE_D);
        flush();
        check("idle_groups", 66'(ngrp), 66'd2);
        for (int g = 0; g < 2; g++)
            for (int l = 0; l < 4; l++) check_lane("idle", g, l, IDLE_BLK);
        check("idle_ctrl", 66'(o_ctrl_count), 66'd8);
        check("idle_blocks", 66'(o_block_count), 66'd8);

        // Idle, S, D, T at lane 3
        send(1'b1, IDLE_C, IDLE_D);
        send(1'b1, 8'h01, 64'hAAAAAAAAAAAAAAFB);
        send(1'b1, 8'h00, 64'hAAAAAAAAAAAAAAAA);
        send(1'b1, 8'hF8, 64'h07070707FDAAAAAA);
        flush();
        check_lane("frm", 2, 0, IDLE_BLK);
        check_lane("frm", 2, 1, S_BLK);
        check_lane("frm", 2, 2, DAA_BLK);
        check_lane("frm", 2, 3, {56'h00000000AAAAAA, 8'hB4, 2'b01});
        check("frm_err", 66'(o_err_count), 66'd0);
        check("frm_data", 66'(o_data_count), 66'd1);

        // Terminate sweep k=0..7, each preceded by a start
        for (int k = 0; k < 8; k++) begin
            send(1'b1, 8'h01, 64'hAAAAAAAAAAAAAAFB);
            d = IDLE_D;
            for (int i = 0; i < k; i++) d[8*i +: 8] = 8'hAA;
            d[8*k +: 8] = 8'hFD;
            c = 8'hFF << k;
            send(1'b1, c, d);
        end
        flush();
        for (int k = 0; k < 8; k++) begin
            p = 56'h0;
            for (int i = 0; i < k; i++) p[8*i +: 8] = 8'hAA;
            check_lane("sweep_s", 3 + k / 2, (k % 2) * 2, S_BLK);
            check_lane($sformatf("sweep_t%0d", k), 3 + k / 2, (k % 2) * 2 + 1, {p, tt[k], 2'b01});
        end

        // Terminate at lane 5 with error bytes in the tail
        send(1'b1, 8'h01, 64'hAAAAAAAAAAAAAAFB);
        send(1'b1, 8'hE0, 64'hFEFEFD5544332211);
        send(1'b1, IDLE_C, IDLE_D);
        send(1'b1, IDLE_C, IDLE_D);
        flush();
        check_lane("t5err", 7, 1, {56'h3C785544332211, 8'hD2, 2'b01});

        // Illegal C->D, recovery, then a bad control byte
        send(1'b1, IDLE_C, IDLE_D);
        send(1'b1, 8'h00, 64'hAAAAAAAAAAAAAAAA);
        send(1'b1, IDLE_C, IDLE_D);
        send(1'b1, IDLE_C, 64'h070707075C070707);
        flush();
        check_lane("illegal", 8, 0, IDLE_BLK);
        check_lane("illegal", 8, 1, EBLK);
        check_lane("illegal", 8, 2, IDLE_BLK);
        check_lane("illegal", 8, 3, EBLK);
        check("illegal_err", 66'(o_err_count), 66'd2);

        // Error bytes in an idle word encode as 7'h1E without an error
        send(1'b1, IDLE_C, 64'h07070707FEFE0707);
        for (int i = 0; i < 3; i++) send(1'b1, IDLE_C, IDLE_D);
        flush();
        check_lane("fe_idle", 9, 0, {56'h00000003C78000, 8'h1E, 2'b01});
        check("fe_err", 66'(o_err_count), 66'd2);
        check("tot_blocks", 66'(o_block_count), 66'd40);
        check("tot_data", 66'(o_data_count), 66'd1);
        check("tot_ctrl", 66'(o_ctrl_count), 66'd39);
        check("tot_groups", 66'(ngrp), 66'd10);

        // Mid-group reset, then stalls between accepted words
        send(1'b1, IDLE_C, IDLE_D);
        send(1'b1, IDLE_C, IDLE_D);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("mrst_lane0", o_tx_coded_0, 66'd0);
        check("mrst_lane3", o_tx_coded_3, 66'd0);
        check("mrst_blocks", 66'(o_block_count), 66'd0);
        check("mrst_err", 66'(o_err_count), 66'd0);
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        base = ngrp;
        send(1'b1, 8'h01, 64'hAAAAAAAAAAAAAAFB);
        send(1'b0, IDLE_C, IDLE_D);
        send(1'b1, 8'h00, 64'hAAAAAAAAAAAAAAAA);
        send(1'b0, IDLE_C, IDLE_D);
        check("stall_blocks", 66'(o_block_count), 66'd2);
        send(1'b1, 8'h00, 64'h5555555555555555);
        send(1'b0, IDLE_C, IDLE_D);
        check("no_early_valid", 66'(ngrp), 66'(base));
        send(1'b1, IDLE_C, 64'h07070707070707FD);
        flush();
        check("post_rst_groups", 66'(ngrp), 66'(base + 1));
        check_lane("post_rst", base, 0, S_BLK);
        check_lane("post_rst", base, 1, DAA_BLK);
        check_lane("post_rst", base, 2, {64'h5555555555555555, 2'b10});
        check_lane("post_rst", base, 3, {56'h0, 8'h87, 2'b01});
        check("post_rst_data", 66'(o_data_count), 66'd2);
        check("post_rst_ctrl", 66'(o_ctrl_count), 66'd2);
        check("post_rst_err", 66'(o_err_count), 66'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
